// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack handshake moving one word into another clock domain.
// Ports:
//   clk         source-domain clock
//   rstn        asynchronous active-low reset
//   s_data      word to transfer
//   s_valid     word present
//   s_ready     controller idle; word accepted on s_valid & s_ready
//   cdc_data    registered word, held stable for the whole handshake
//   cdc_req     registered level request to the destination domain
//   cdc_ack     asynchronous level acknowledge from the destination domain
//   done        one-cycle pulse, transfer completed
//   timeout_err one-cycle pulse, transfer aborted because ack never arrived

// synchronizer: multi-flop level resynchronizer, cleared by reset; C_STAGES must be >= 2.
module synchronizer #(
    parameter int C_STAGES = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [C_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[C_STAGES-2:0], d};
    assign q = sync_q[C_STAGES-1];
endmodule

module cdc_handshake_tx #(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_SYNC_STAGES = 3,
    parameter int C_TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [C_DATA_WIDTH-1:0] cdc_data,
    output logic                    cdc_req,
    input  logic                    cdc_ack,
    output logic                    done,
    output logic                    timeout_err
);
    localparam int CW = C_TIMEOUT > 1 ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(C_TIMEOUT > 0 ? C_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t                  state_q;
    logic                    ready_q, req_q, done_q, terr_q, abort_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]           cnt_q;
    logic                    ack_sync;

    synchronizer #(.C_STAGES(C_SYNC_STAGES)) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (cdc_ack),
        .q    (ack_sync)
    );

    // A late ack left over from an aborted transfer must never look like a fresh handshake.
    assign s_ready     = ready_q & ~ack_sync;
    assign cdc_data    = data_q;
    assign cdc_req     = req_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            terr_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (s_valid && s_ready) begin
                        data_q  <= s_data;
                        req_q   <= 1'b1;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                        state_q <= REQ;
                    end
                REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    // ack is tested first so a simultaneous ack and timeout completes normally
                    if (ack_sync) begin
                        req_q   <= 1'b0;
                        state_q <= RELEASE;
                    end else if (C_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        req_q   <= 1'b0;
                        terr_q  <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= RELEASE;
                    end
                end
                RELEASE:
                    if (!ack_sync) begin
                        ready_q <= 1'b1;
                        done_q  <= ~abort_q;
                        state_q <= IDLE;
                    end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed vector table plus hand-written handshake sequences for cdc_handshake_tx.
`timescale 1ns/100ps
module tb_cdc_handshake_tx;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] cdc_data;
    logic        cdc_req;
    logic        cdc_ack;
    logic        done;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    logic dst_en = 1'b0;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .C_DATA_WIDTH  (32),
        .C_SYNC_STAGES (3),
        .C_TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .cdc_data    (cdc_data),
        .cdc_req     (cdc_req),
        .cdc_ack     (cdc_ack),
        .done        (done),
        .timeout_err (timeout_err)
    );

    // Destination model: ack rises 2 clocks after req is seen, falls 2 clocks after req drops.
    initial begin
        int hi, lo;
        hi = 0;
        lo = 0;
        forever begin
            @(negedge clk);
            if (!dst_en) begin
                hi = 0;
                lo = 0;
            end else if (cdc_req) begin
                lo = 0;
                hi++;
                if (hi >= 2) cdc_ack = 1'b1;
            end else begin
                hi = 0;
                lo++;
                if (lo >= 2) cdc_ack = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        int          n;
        logic        v;
        logic [31:0] d;
        logic        a;
        logic        rdy;
        logic        req;
        logic        dn;
        logic        te;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[16];
    logic [31:0] words[3];

    initial begin
        int fall, dcyc, dn, te, bad, idx, ov;
        logic acc;
        // timeout, stale ack in IDLE, then a normal manually-acked transfer
        tbl[0]  = '{1,  1'b1, 32'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1111};
        tbl[1]  = '{15, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1111};
        tbl[2]  = '{1,  1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111};
        tbl[3]  = '{1,  1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1111};
        tbl[4]  = '{2,  1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1111};
        tbl[5]  = '{1,  1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111};
        tbl[6]  = '{8,  1'b1, 32'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111};
        tbl[7]  = '{2,  1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111};
        tbl[8]  = '{1,  1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1111};
        tbl[9]  = '{1,  1'b1, 32'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3333};
        tbl[10] = '{2,  1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3333};
        tbl[11] = '{3,  1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3333};
        tbl[12] = '{1,  1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3333};
        tbl[13] = '{3,  1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3333};
        tbl[14] = '{1,  1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3333};
        tbl[15] = '{2,  1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3333};
        words[0] = 32'h1;
        words[1] = 32'h2;
        words[2] = 32'h3;

        rstn    = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        cdc_ack = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("reset s_ready", s_ready, 1);
        chk("reset cdc_req", cdc_req, 0);
        chk("reset cdc_data", cdc_data, 0);
        chk("reset done", done, 0);
        chk("reset timeout_err", timeout_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 16; i++)
            for (int k = 0; k < tbl[i].n; k++) begin
                s_valid = tbl[i].v;
                s_data  = tbl[i].d;
                cdc_ack = tbl[i].a;
                step();
                chk($sformatf("vec%0d.%0d s_ready", i, k), s_ready, tbl[i].rdy);
                chk($sformatf("vec%0d.%0d cdc_req", i, k), cdc_req, tbl[i].req);
                chk($sformatf("vec%0d.%0d done", i, k), done, tbl[i].dn);
                chk($sformatf("vec%0d.%0d timeout_err", i, k), timeout_err, tbl[i].te);
                chk($sformatf("vec%0d.%0d cdc_data", i, k), cdc_data, tbl[i].dat);
            end

        // ack_sync and the last timeout count land on the same edge: ack wins
        s_valid = 1'b1;
        s_data  = 32'hC0C0_0001;
        step();
        s_valid = 1'b0;
        repeat (12) step();
        cdc_ack = 1'b1;
        repeat (3) step();
        chk("collide req before", cdc_req, 1);
        step();
        chk("collide req dropped", cdc_req, 0);
        te = timeout_err ? 1 : 0;
        dn = 0;
        cdc_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done) dn++;
            if (timeout_err) te++;
        end
        chk("collide done count", dn, 1);
        chk("collide timeout_err count", te, 0);

        // basic transfer against the destination model
        dst_en  = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        step();
        s_valid = 1'b0;
        chk("basic req after accept", cdc_req, 1);
        chk("basic data after accept", cdc_data, 32'hA5A5_0001);
        fall = -1;
        dcyc = -1;
        dn = 0;
        te = 0;
        bad = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (!cdc_req && fall < 0) fall = c;
            if (done) begin
                dn++;
                dcyc = c;
            end
            if (timeout_err) te++;
            if (cdc_data !== 32'hA5A5_0001) bad++;
        end
        chk("basic req fall cycle", fall, 5);
        chk("basic done cycle", dcyc, 10);
        chk("basic done count", dn, 1);
        chk("basic timeout_err count", te, 0);
        chk("basic data unstable cycles", bad, 0);
        chk("basic s_ready at end", s_ready, 1);

        // back-to-back words with s_valid held high
        idx = 0;
        dn = 0;
        ov = 0;
        s_valid = 1'b1;
        s_data  = words[0];
        for (int c = 0; c < 80 && dn < 3; c++) begin
            acc = s_valid && s_ready;
            step();
            if (acc) begin
                chk($sformatf("b2b accept word%0d", idx), cdc_data, words[idx]);
                idx++;
                if (idx < 3) s_data = words[idx];
                else s_valid = 1'b0;
            end
            if (s_ready && cdc_req) ov++;
            if (done) begin
                chk($sformatf("b2b done word%0d", dn), cdc_data, words[dn]);
                dn++;
            end
        end
        chk("b2b accepts", idx, 3);
        chk("b2b done count", dn, 3);
        chk("b2b ready while req", ov, 0);
        dst_en = 1'b0;
        cdc_ack = 1'b0;
        step();

        // asynchronous reset in the middle of REQ
        s_valid = 1'b1;
        s_data  = 32'hDEAD_0001;
        step();
        s_valid = 1'b0;
        repeat (3) step();
        chk("rst pre req", cdc_req, 1);
        #2 rstn = 1'b0;
        #0.5;
        chk("rst async req", cdc_req, 0);
        chk("rst async done", done, 0);
        chk("rst async timeout_err", timeout_err, 0);
        chk("rst async s_ready", s_ready, 1);
        chk("rst async data", cdc_data, 0);
        #0.5 rstn = 1'b1;
        step();
        chk("rst after s_ready", s_ready, 1);
        chk("rst after req", cdc_req, 0);
        chk("rst after data", cdc_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
